mem_access_unit: RTL

Memory-stage data-memory access unit of the pipelined RV32I core. It sits between the EX/MEM pipeline register and the MEM/WB register, turning load/store instructions in M into single transactions on a req/ready data-memory bus. It stalls the pipeline until each transaction completes, aligns and extends load data into ReadDataM, and flags misaligned accesses.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/mem_access_unit_if.sv | 22 ++
 rtl/load_extend.sv | 35 +++
 rtl/mem_access_unit.sv | 129 ++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants, FSM state type and alignment helper for the data-memory access unit.
package mem_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned BE_W = XLEN / 8;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } mau_state_e;

   // funct3[1:0] encodes size; 00 byte, 01 half, anything else is a word access.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      logic mis;
      case (f3[1:0])
         2'b00:   mis = 1'b0;
         2'b01:   mis = off[0];
         default: mis = (off != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory req/ready bus between the access unit (master) and memory (slave).
interface mem_access_unit_if
   import mem_pkg::*;
   ;
   logic            dmem_req;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [XLEN-1:0] dmem_wdata;
   logic [BE_W-1:0] dmem_be;
   logic [XLEN-1:0] dmem_rdata;
   logic            dmem_ready;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_rdata, dmem_ready
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_rdata, dmem_ready
   );
endinterface

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword lane of a read word and sign/zero extends it.
module load_extend
   import mem_pkg::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      addr,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] ext_data
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane select, then extension by access type; undefined funct3 passes the word through.
   always_comb begin
      byte_s   = rdata[7:0];
      half_s   = addr[1] ? rdata[31:16] : rdata[15:0];
      ext_data = rdata;
      case (addr)
         2'b00:   byte_s = rdata[7:0];
         2'b01:   byte_s = rdata[15:8];
         2'b10:   byte_s = rdata[23:16];
         default: byte_s = rdata[31:24];
      endcase
      case (funct3)
         F3_B:    ext_data = {{24{byte_s[7]}}, byte_s};
         F3_H:    ext_data = {{16{half_s[15]}}, half_s};
         F3_BU:   ext_data = {24'h000000, byte_s};
         F3_HU:   ext_data = {16'h0000, half_s};
         F3_W:    ext_data = rdata;
         default: ext_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: turns a load/store in M into one req/ready transaction,
// stalls the pipeline until it completes and returns aligned, extended load data.
module mem_access_unit
   import mem_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             MemWriteM,
   input  logic [1:0]       ResultSrcM,
   input  logic [2:0]       funct3M,
   input  logic [XLEN-1:0]  ALUResultM,
   input  logic [XLEN-1:0]  WriteDataM,
   output logic             StallM,
   output logic             MisalignM,
   output logic [XLEN-1:0]  ReadDataM,
   mem_access_unit_if.master dmem
);

   mau_state_e      state_q;
   logic            req_q;
   logic            we_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [BE_W-1:0] be_q;
   logic [1:0]      off_q;
   logic [2:0]      f3_q;
   logic [XLEN-1:0] rdata_q;

   logic            memop;
   logic            misal;
   logic [BE_W-1:0] be_d;
   logic [XLEN-1:0] wdata_d;
   logic [XLEN-1:0] ext_data;

   assign memop = MemWriteM | (ResultSrcM == RESULT_SRC_LOAD);
   assign misal = is_misaligned(funct3M, ALUResultM[1:0]);

   // Byte enables and lane-replicated store data for the request about to be issued.
   always_comb begin
      be_d    = 4'b1111;
      wdata_d = '0;
      if (MemWriteM) begin
         case (funct3M[1:0])
            2'b00: begin
               be_d    = 4'b0001 << ALUResultM[1:0];
               wdata_d = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
               be_d    = 4'b0011 << {ALUResultM[1], 1'b0};
               wdata_d = {2{WriteDataM[15:0]}};
            end
            default: begin
               be_d    = 4'b1111;
               wdata_d = WriteDataM;
            end
         endcase
      end
   end

   // Stall and misalign flags follow the FSM state; both held low during reset.
   always_comb begin
      StallM    = 1'b0;
      MisalignM = 1'b0;
      if (rst_n) begin
         case (state_q)
            IDLE: begin
               StallM    = memop & ~misal;
               MisalignM = memop & misal;
            end
            BUSY:    StallM = 1'b1;
            default: StallM = 1'b0;
         endcase
      end
   end

   load_extend u_load_extend (
      .rdata    (dmem.dmem_rdata),
      .addr     (off_q),
      .funct3   (f3_q),
      .ext_data (ext_data)
   );

   // Transaction FSM with registered bus outputs and load result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         off_q   <= '0;
         f3_q    <= '0;
         rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (memop && !misal) begin
                  req_q   <= 1'b1;
                  we_q    <= MemWriteM;
                  addr_q  <= {ALUResultM[XLEN-1:2], 2'b00};
                  be_q    <= be_d;
                  wdata_q <= wdata_d;
                  off_q   <= ALUResultM[1:0];
                  f3_q    <= funct3M;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (dmem.dmem_ready) begin
                  req_q <= 1'b0;
                  if (!we_q) rdata_q <= ext_data;
                  state_q <= DONE;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dmem.dmem_req   = req_q;
   assign dmem.dmem_we    = we_q;
   assign dmem.dmem_addr  = addr_q;
   assign dmem.dmem_wdata = wdata_q;
   assign dmem.dmem_be    = be_q;
   assign ReadDataM       = rdata_q;

endmodule
